// File: rtl/down_timer.sv
// Loadable down-counter/timer with one-cycle done pulse and IDLE/RUN/DONE sequencing.
// Define DOWN_TIMER_AUTO_RELOAD_EN to restart from the reload value after each done pulse.
module down_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] reload;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
    end else if (load) begin
      state  <= IDLE;
      count  <= data;
      reload <= data;
    end else if (stop) begin
      // In IDLE this is a no-op, but it still masks a coincident start.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= (count != '0) ? RUN : DONE;
        end
        RUN: begin
          if (enable && count != '0) begin
            count <= count - ONE;
            if (count == ONE) state <= DONE;
          end
        end
        DONE: begin
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
          if (reload != '0) begin
            state <= RUN;
            count <= reload;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign zero = (count == '0);

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer: vector table plus hand-written corner sequences.
module tb_down_timer;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst, load, start, stop, enable;
  logic [W-1:0] data;
  logic [W-1:0] count;
  logic         busy, done, zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         rst, load, start, stop, enable;
    logic [W-1:0] data;
    logic [W-1:0] exp_count;
    logic         exp_busy, exp_done, exp_zero;
  } vec_t;

  vec_t vecs[16];

  down_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .data(data), .load(load), .start(start), .stop(stop),
    .enable(enable), .count(count), .busy(busy), .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic l, logic s, logic p, logic e, int d,
                              int c, logic b, logic dn, logic z);
    vec_t v;
    v.rst = r; v.load = l; v.start = s; v.stop = p; v.enable = e;
    v.data = W'(d); v.exp_count = W'(c);
    v.exp_busy = b; v.exp_done = dn; v.exp_zero = z;
    return v;
  endfunction

  task automatic check(string name, logic [W-1:0] c, logic b, logic dn, logic z);
    checks++;
    if (count !== c || busy !== b || done !== dn || zero !== z) begin
      errors++;
      $display("FAIL %s: got count=%0d busy=%b done=%b zero=%b, want count=%0d busy=%b done=%b zero=%b",
               name, count, busy, done, zero, c, b, dn, z);
    end
  endtask

  // Drive inputs just after an edge, then sample #1 after the next edge.
  task automatic step(logic r, logic l, logic s, logic p, logic e, int d);
    rst = r; load = l; start = s; stop = p; enable = e; data = W'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(string name, logic r, logic l, logic s, logic p, logic e, int d,
                          int c, logic b, logic dn, logic z);
    step(r, l, s, p, e, d);
    check(name, W'(c), b, dn, z);
  endtask

  initial begin
    //              rst ld st sp en  d    cnt busy done zero
    vecs[0]  = mk(0, 1, 0, 0, 0, 5,   5, 0, 0, 0);
    vecs[1]  = mk(0, 0, 1, 0, 1, 0,   5, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 1, 0,   4, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 1, 0,   3, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 1, 0,   2, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 1, 0,   1, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 1, 0,   0, 0, 1, 1);
    vecs[7]  = mk(0, 0, 0, 0, 1, 0,   0, 0, 0, 1);
    vecs[8]  = mk(0, 1, 0, 0, 0, 3,   3, 0, 0, 0);
    vecs[9]  = mk(0, 0, 1, 0, 1, 0,   3, 1, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 1, 0,   2, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0,   2, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 1, 0,   1, 1, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 1, 0,   0, 0, 1, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 1);

    // Reset for two cycles with random side inputs.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(31)));
      check("reset", '0, 1'b0, 1'b0, 1'b1);
    end

    // Basic countdown from 5, then gated-enable countdown from 3.
    for (int i = 0; i < 16; i++) begin
      step_chk($sformatf("vec%0d", i), vecs[i].rst, vecs[i].load, vecs[i].start, vecs[i].stop,
               vecs[i].enable, int'(vecs[i].data), int'(vecs[i].exp_count),
               vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_zero);
    end

    // Load mid-run cancels the run without a done pulse.
    step_chk("ovr_load4",  0, 1, 0, 0, 0, 4,  4, 0, 0, 0);
    step_chk("ovr_start",  0, 0, 1, 0, 1, 0,  4, 1, 0, 0);
    step_chk("ovr_dec3",   0, 0, 0, 0, 1, 0,  3, 1, 0, 0);
    step_chk("ovr_dec2",   0, 0, 0, 0, 1, 0,  2, 1, 0, 0);
    step_chk("ovr_load7",  0, 1, 0, 0, 1, 7,  7, 0, 0, 0);
    step_chk("ovr_idle",   0, 0, 0, 0, 1, 0,  7, 0, 0, 0);

    // Stop coinciding with the final decrement wins.
    step_chk("stp_load2",  0, 1, 0, 0, 0, 2,  2, 0, 0, 0);
    step_chk("stp_start",  0, 0, 1, 0, 1, 0,  2, 1, 0, 0);
    step_chk("stp_dec1",   0, 0, 0, 0, 1, 0,  1, 1, 0, 0);
    step_chk("stp_final",  0, 0, 0, 1, 1, 0,  1, 0, 0, 0);
    step_chk("stp_after",  0, 0, 0, 0, 1, 0,  1, 0, 0, 0);

    // Start with count=0 goes straight to DONE for one cycle.
    step_chk("zs_load0",   0, 1, 0, 0, 0, 0,  0, 0, 0, 1);
    step_chk("zs_start",   0, 0, 1, 0, 1, 0,  0, 0, 1, 1);
    step_chk("zs_after",   0, 0, 0, 0, 1, 0,  0, 0, 0, 1);

    // Reset mid-run suppresses the pending done.
    step_chk("rr_load6",   0, 1, 0, 0, 0, 6,  6, 0, 0, 0);
    step_chk("rr_start",   0, 0, 1, 0, 1, 0,  6, 1, 0, 0);
    step_chk("rr_dec5",    0, 0, 0, 0, 1, 0,  5, 1, 0, 0);
    step_chk("rr_dec4",    0, 0, 0, 0, 1, 0,  4, 1, 0, 0);
    step_chk("rr_reset",   1, 0, 0, 0, 1, 0,  0, 0, 0, 1);
    step_chk("rr_after",   0, 0, 0, 0, 1, 0,  0, 0, 0, 1);

    // Load and start together: load wins and start is dropped.
    step_chk("ls_both",    0, 1, 1, 0, 1, 3,  3, 0, 0, 0);
    step_chk("ls_after",   0, 0, 0, 0, 1, 0,  3, 0, 0, 0);

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    // Periodic run from reload=2: done every third cycle until stop.
    step_chk("ar_load2",   0, 1, 0, 0, 0, 2,  2, 0, 0, 0);
    step_chk("ar_start",   0, 0, 1, 0, 1, 0,  2, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      step_chk("ar_dec1",  0, 0, 0, 0, 1, 0,  1, 1, 0, 0);
      step_chk("ar_done",  0, 0, 0, 0, 1, 0,  0, 0, 1, 1);
      step_chk("ar_reld",  0, 0, 0, 0, 1, 0,  2, 1, 0, 0);
    end
    step_chk("ar_stop",    0, 0, 0, 1, 1, 0,  2, 0, 0, 0);
    step_chk("ar_idle",    0, 0, 0, 0, 1, 0,  2, 0, 0, 0);
`else
    // Without auto-reload, DONE returns to IDLE and a load does not restart.
    step_chk("nr_load1",   0, 1, 0, 0, 0, 1,  1, 0, 0, 0);
    step_chk("nr_start",   0, 0, 1, 0, 1, 0,  1, 1, 0, 0);
    step_chk("nr_done",    0, 0, 0, 0, 1, 0,  0, 0, 1, 1);
    step_chk("nr_idle",    0, 0, 0, 0, 1, 0,  0, 0, 0, 1);
    step_chk("nr_hold",    0, 0, 0, 0, 1, 0,  0, 0, 0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
